eth_sb_ctrl_arbiter: RTL and testbench
======================================

# eth_sb_ctrl_arbiter

Two-requester arbiter and sequencer for the ETH sideband controller register port. It shares the single controller write/read interface between the APB sideband FSM (requester 0) and the AXI sideband path (requester 1). Each transaction is issued to the controller as a one-cycle enable pulse, then held until the controller's write/read response or a timeout. Completion, read data and error status are returned to the granted requester only.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before forced error completion (>=2)
- i_clk  in  1  clock
- i_reset  in  1  reset; one clock; reset is synchronous and active-high
- i_fuse_enable  in  1  mode select: 0 = requester 0 (APB) masked, 1 = both requesters eligible
- i_reqN_wr_en, i_reqN_rd_en  in  1 each  (N=0,1) level request, held until o_reqN_done
- i_reqN_addr  in  ADDR_WIDTH; i_reqN_wdata  in  DATA_WIDTH; i_reqN_pstrb  in  4: request payload, stable while requesting
- o_reqN_done  out  1  one-cycle completion pulse
- o_reqN_rdata  out  DATA_WIDTH  read data, valid with done (0 for writes)
- o_reqN_slverr  out  1  error, valid with done
- o_ctrl_wr_en, o_ctrl_rd_en  out  1  one-cycle enable pulses to the controller
- o_ctrl_addr  out  ADDR_WIDTH; o_ctrl_wdata  out  DATA_WIDTH; o_ctrl_pstrb  out  4: captured payload
- i_ctrl_rdata  in  DATA_WIDTH; i_ctrl_slverr  in  1; i_ctrl_inv_addr  in  1
- i_wdata_resp, i_rdata_resp  in  1  controller write/read completion pulses
- o_grant  out  2  one-hot owner, nonzero from ISSUE through RESP
- o_busy  out  1  state != IDLE

## Operation
**States**
- IDLE
  - Eligible requests: req1 any time; req0 only when i_fuse_enable=1.
  - If any eligible request: choose the grant, capture addr, wdata, pstrb and op into registers, then go to ISSUE.
  - Op is write if wr_en=1; a write wins if wr_en and rd_en are both high.
- ISSUE
  - Assert o_ctrl_wr_en or o_ctrl_rd_en for exactly this cycle.
  - Clear the timeout counter, then go to WAIT.
  - Any response arriving in this cycle is ignored.
- WAIT
  - Write ops wait for i_wdata_resp; read ops wait for i_rdata_resp. A response of the wrong type is ignored.
  - On the matching response: capture rdata (reads only; writes capture 0) and slverr = i_ctrl_slverr | i_ctrl_inv_addr, then go to RESP.
  - Otherwise the counter increments.
  - If the counter equals TIMEOUT_CYCLES-1 with no response: slverr=1, rdata=0, go to RESP.
- RESP
  - Pulse o_reqN_done for the granted N, with o_reqN_rdata and o_reqN_slverr.
  - Update the round-robin pointer to the granted N, then go to IDLE.

**Arbitration and outputs**
- Round-robin: on contention, the requester not granted last wins.
- Non-granted requester outputs stay 0.
- o_ctrl_addr, o_ctrl_wdata and o_ctrl_pstrb hold the captured values from ISSUE until the next capture.
- Counter width is $clog2(TIMEOUT_CYCLES)+1 bits and never wraps.
- Changing i_fuse_enable mid-transaction does not abort it; the change takes effect at the next IDLE.

## Timing
**Reset**
- At the first edge with i_reset=1: state=IDLE, round-robin pointer=1 (req0 wins the first tie), counter=0.
- All outputs are 0: done, rdata, slverr, ctrl enables, addr, wdata, pstrb, o_grant, o_busy.
- Reset mid-transaction drops it: no done pulse and no further ctrl enable.

**Latency**
- Request sampled in IDLE at cycle 0; ctrl enable in cycle 1; response earliest in cycle 2; done in cycle 3.
- Minimum done latency: 3 cycles.
- Maximum done latency: TIMEOUT_CYCLES+2 cycles.

**Handshake**
- The requester deasserts the request in the cycle after it sees done.
- A request still high in the first IDLE cycle after RESP is treated as a new transaction.
- Back-to-back throughput is one transaction per 4 cycles minimum.

**Simultaneous events**
- A matching response in the same cycle the counter reaches TIMEOUT_CYCLES-1 completes normally, not as a timeout.
- A request arriving during ISSUE, WAIT or RESP waits; it is not lost as long as it is held.

## Test plan
- Single write: fuse=1, req0 write addr=0x10, wdata=0xA5A5A5A5, pstrb=0xF; i_wdata_resp in cycle 2.
  - Expect o_ctrl_wr_en in cycle 1 with those values; o_req0_done in cycle 3 with slverr=0, rdata=0.
- Single read: req1 read addr=0x20; i_rdata_resp with i_ctrl_rdata=0xDEADBEEF two cycles after o_ctrl_rd_en.
  - Expect o_req1_done with o_req1_rdata=0xDEADBEEF, slverr=0.
- Contention: both requesters held continuously, fuse=1, right after reset.
  - Expect grants 0,1,0,1 in that order; each done only on its owner; ctrl enables spaced 4 cycles.
- Timeout: TIMEOUT_CYCLES=8, req0 read, no response.
  - Expect o_req0_done 10 cycles after the request with slverr=1, rdata=0.
  - Then a new request is served normally.
- Error and mask:
  - i_ctrl_inv_addr=1 with the response: expect slverr=1.
  - fuse=0 with req0 held: req0 is never granted and req1 is still served.
- Reset mid-WAIT: i_reset=1 during WAIT.
  - Expect all outputs 0 next cycle, no done.
  - After release with req0 and req1 both high, req0 is granted first.

Source files
------------

// File: rtl/eth_sb_ctrl_arbiter.sv
// Two-requester arbiter/sequencer for the ETH sideband controller register port.
// It issues one-cycle controller enables and returns the completion to the granted requester.
module eth_sb_ctrl_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fuse_enable,
  input  logic                  i_req0_wr_en,
  input  logic                  i_req0_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  input  logic [3:0]            i_req0_pstrb,
  output logic                  o_req0_done,
  output logic [DATA_WIDTH-1:0] o_req0_rdata,
  output logic                  o_req0_slverr,
  input  logic                  i_req1_wr_en,
  input  logic                  i_req1_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  input  logic [3:0]            i_req1_pstrb,
  output logic                  o_req1_done,
  output logic [DATA_WIDTH-1:0] o_req1_rdata,
  output logic                  o_req1_slverr,
  output logic                  o_ctrl_wr_en,
  output logic                  o_ctrl_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ctrl_addr,
  output logic [DATA_WIDTH-1:0] o_ctrl_wdata,
  output logic [3:0]            o_ctrl_pstrb,
  input  logic [DATA_WIDTH-1:0] i_ctrl_rdata,
  input  logic                  i_ctrl_slverr,
  input  logic                  i_ctrl_inv_addr,
  input  logic                  i_wdata_resp,
  input  logic                  i_rdata_resp,
  output logic [1:0]            o_grant,
  output logic                  o_busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  rr_q, rr_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic elig0, elig1, pick1, match;

  assign elig0 = i_fuse_enable & (i_req0_wr_en | i_req0_rd_en);
  assign elig1 = i_req1_wr_en | i_req1_rd_en;
  // rr_q holds the last owner; requester 1 wins a tie only if requester 0 went last
  assign pick1 = elig1 & (~elig0 | ~rr_q);
  assign match = op_wr_q ? i_wdata_resp : i_rdata_resp;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      grant_q  <= 2'b00;
      rr_q     <= 1'b1;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          state_d = StIssue;
          grant_d = pick1 ? 2'b10 : 2'b01;
          op_wr_d = pick1 ? i_req1_wr_en : i_req0_wr_en;
          addr_d  = pick1 ? i_req1_addr  : i_req0_addr;
          wdata_d = pick1 ? i_req1_wdata : i_req0_wdata;
          pstrb_d = pick1 ? i_req1_pstrb : i_req0_pstrb;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A matching response beats a simultaneous timeout
        if (match) begin
          rdata_d  = op_wr_q ? '0 : i_ctrl_rdata;
          slverr_d = i_ctrl_slverr | i_ctrl_inv_addr;
          state_d  = StResp;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d  = '0;
          slverr_d = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        rr_d    = grant_q[1];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_ctrl_wr_en  = (state_q == StIssue) & op_wr_q;
    o_ctrl_rd_en  = (state_q == StIssue) & ~op_wr_q;
    o_ctrl_addr   = addr_q;
    o_ctrl_wdata  = wdata_q;
    o_ctrl_pstrb  = pstrb_q;
    o_busy        = (state_q != StIdle);
    o_grant       = o_busy ? grant_q : 2'b00;
    o_req0_done   = (state_q == StResp) & grant_q[0];
    o_req1_done   = (state_q == StResp) & grant_q[1];
    o_req0_rdata  = o_req0_done ? rdata_q : '0;
    o_req1_rdata  = o_req1_done ? rdata_q : '0;
    o_req0_slverr = o_req0_done & slverr_q;
    o_req1_slverr = o_req1_done & slverr_q;
  end

endmodule

// File: tb/tb_eth_sb_ctrl_arbiter.sv
// Directed bench for eth_sb_ctrl_arbiter: a controller responder model plus a completion
// scoreboard that checks owner, data, error and cycle of every done pulse.
module tb_eth_sb_ctrl_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fuse;
  logic        r0_wr, r0_rd, r1_wr, r1_rd;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_pstrb, r1_pstrb;
  logic        d0, d1, e0, e1;
  logic [31:0] rd0, rd1;
  logic        c_wr, c_rd;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_pstrb;
  logic [31:0] c_rdata;
  logic        c_err, c_inv, wresp, rresp;
  logic [1:0]  grant;
  logic        busy;

  eth_sb_ctrl_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_fuse_enable  (fuse),
    .i_req0_wr_en   (r0_wr),
    .i_req0_rd_en   (r0_rd),
    .i_req0_addr    (r0_addr),
    .i_req0_wdata   (r0_wdata),
    .i_req0_pstrb   (r0_pstrb),
    .o_req0_done    (d0),
    .o_req0_rdata   (rd0),
    .o_req0_slverr  (e0),
    .i_req1_wr_en   (r1_wr),
    .i_req1_rd_en   (r1_rd),
    .i_req1_addr    (r1_addr),
    .i_req1_wdata   (r1_wdata),
    .i_req1_pstrb   (r1_pstrb),
    .o_req1_done    (d1),
    .o_req1_rdata   (rd1),
    .o_req1_slverr  (e1),
    .o_ctrl_wr_en   (c_wr),
    .o_ctrl_rd_en   (c_rd),
    .o_ctrl_addr    (c_addr),
    .o_ctrl_wdata   (c_wdata),
    .o_ctrl_pstrb   (c_pstrb),
    .i_ctrl_rdata   (c_rdata),
    .i_ctrl_slverr  (c_err),
    .i_ctrl_inv_addr(c_inv),
    .i_wdata_resp   (wresp),
    .i_rdata_resp   (rresp),
    .o_grant        (grant),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          resp_delay = 1;
  int          pend_cyc = -1;
  logic        pend_wr = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        resp_inv = 1'b0;
  bit          hold0 = 1'b0;
  bit          hold1 = 1'b0;
  int          r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int req, input logic [31:0] rdata, input logic err, input int dc);
    exp_t e;
    e.req = req; e.rdata = rdata; e.err = err; e.cyc = dc;
    sb.push_back(e);
  endtask

  task automatic set_req(input int n, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] pstrb);
    if (n == 0) begin
      r0_wr = wr; r0_rd = !wr; r0_addr = addr; r0_wdata = wdata; r0_pstrb = pstrb;
    end else begin
      r1_wr = wr; r1_rd = !wr; r1_addr = addr; r1_wdata = wdata; r1_pstrb = pstrb;
    end
  endtask

  // One clock: drive controller responses, then check any completion against the scoreboard
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    wresp = 1'b0; rresp = 1'b0; c_inv = 1'b0; c_err = 1'b0; c_rdata = '0;
    if (pend_cyc == cyc) begin
      wresp = pend_wr; rresp = !pend_wr; c_rdata = resp_rdata; c_inv = resp_inv;
      pend_cyc = -1;
    end
    if ((c_wr || c_rd) && resp_delay > 0) begin
      pend_cyc = cyc + resp_delay;
      pend_wr  = c_wr;
    end
    if (d0 || d1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'({d1, d0}), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("done_owner", 64'({d1, d0}), (e.req == 1) ? 64'(2) : 64'(1));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("done_rdata", 64'((e.req == 1) ? rd1 : rd0), 64'(e.rdata));
        chk("done_slverr", 64'((e.req == 1) ? e1 : e0), 64'(e.err));
        chk("idle_side_outs", 64'((e.req == 1) ? {rd0, e0} : {rd1, e1}), 64'(0));
        if (e.req == 0 && !hold0) begin r0_wr = 1'b0; r0_rd = 1'b0; end
        if (e.req == 1 && !hold1) begin r1_wr = 1'b0; r1_rd = 1'b0; end
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) step();
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({c_wr, c_rd, c_pstrb, grant, busy}), 64'(0));
    chk({tag, "_addr_wdata"}, {c_addr, c_wdata}, 64'(0));
    chk({tag, "_req_outs"}, 64'({d0, e0, d1, e1}), 64'(0));
    chk({tag, "_rdata"}, {rd0, rd1}, 64'(0));
  endtask

  initial begin
    rst = 1'b1; fuse = 1'b1;
    r0_wr = 0; r0_rd = 0; r1_wr = 0; r1_rd = 0;
    r0_addr = '0; r0_wdata = '0; r0_pstrb = '0; r1_addr = '0; r1_wdata = '0; r1_pstrb = '0;
    c_rdata = '0; c_err = 0; c_inv = 0; wresp = 0; rresp = 0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Contention straight out of reset: 0,1,0,1 with enables 4 cycles apart
    r = cyc; hold0 = 1; hold1 = 1; resp_delay = 1; resp_rdata = 32'h1111_2222;
    set_req(0, 1, 32'h100, 32'h0BAD_F00D, 4'h3);
    set_req(1, 0, 32'h200, 32'h0, 4'hF);
    push(0, 32'h0, 1'b0, r + 3);
    push(1, 32'h1111_2222, 1'b0, r + 7);
    push(0, 32'h0, 1'b0, r + 11);
    push(1, 32'h1111_2222, 1'b0, r + 15);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("cont_grant", 64'(grant), (k % 2 == 0) ? 64'(1) : 64'(2));
      chk("cont_enables", 64'({c_wr, c_rd}), (k % 2 == 0) ? 64'(2) : 64'(1));
      chk("cont_addr", 64'(c_addr), (k % 2 == 0) ? 64'h100 : 64'h200);
      repeat (3) step();
    end
    hold0 = 0; hold1 = 0;
    r0_wr = 0; r0_rd = 0; r1_wr = 0; r1_rd = 0;
    chk("cont_drained", 64'(sb.size()), 64'(0));

    // Single write, minimum latency
    r = cyc;
    set_req(0, 1, 32'h10, 32'hA5A5_A5A5, 4'hF);
    push(0, 32'h0, 1'b0, r + 3);
    step();
    chk("wr_enables", 64'({c_wr, c_rd}), 64'(2));
    chk("wr_payload", {c_addr, c_wdata}, 64'h0000_0010_A5A5_A5A5);
    chk("wr_pstrb_grant", 64'({c_pstrb, grant}), 64'({4'hF, 2'b01}));
    drain(); step();

    // Single read, response two cycles after the enable
    r = cyc; resp_delay = 2; resp_rdata = 32'hDEAD_BEEF;
    set_req(1, 0, 32'h20, 32'h0, 4'h0);
    push(1, 32'hDEAD_BEEF, 1'b0, r + 4);
    step();
    chk("rd_enables", 64'({c_wr, c_rd}), 64'(1));
    chk("rd_addr_grant", 64'({c_addr, grant}), 64'({32'h20, 2'b10}));
    drain(); step();

    // Timeout with no response
    r = cyc; resp_delay = 0;
    set_req(0, 0, 32'h30, 32'h0, 4'h0);
    push(0, 32'h0, 1'b1, r + 10);
    repeat (5) step();
    chk("to_busy_grant", 64'({busy, grant}), 64'({1'b1, 2'b01}));
    drain(); step();

    // Invalid address flagged with the response
    r = cyc; resp_delay = 1; resp_inv = 1;
    set_req(1, 1, 32'h40, 32'h1234_5678, 4'h1);
    push(1, 32'h0, 1'b1, r + 3);
    drain(); step();
    resp_inv = 0;

    // Requester 0 masked while requester 1 is served
    r = cyc; fuse = 0; hold0 = 1; resp_rdata = 32'h0000_600D;
    set_req(0, 1, 32'h50, 32'h5555_5555, 4'hF);
    set_req(1, 0, 32'h60, 32'h0, 4'h0);
    push(1, 32'h0000_600D, 1'b0, r + 3);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("mask_no_grant0", 64'(grant[0]), 64'(0));
    end
    chk("mask_drained", 64'(sb.size()), 64'(0));
    hold0 = 0; r0_wr = 0; r0_rd = 0; fuse = 1;

    // Normal service after the timeout; leaves requester 0 as last owner
    r = cyc;
    set_req(0, 1, 32'h34, 32'hCAFE_F00D, 4'h7);
    push(0, 32'h0, 1'b0, r + 3);
    drain(); step();

    // Reset while in WAIT drops the transaction
    r = cyc; resp_delay = 0;
    set_req(1, 0, 32'h70, 32'h0, 4'h0);
    repeat (3) step();
    chk("pre_reset_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    step();
    chk_all_zero("mid_reset");
    rst = 1'b0; pend_cyc = -1; resp_delay = 1; resp_rdata = 32'hCAFE_0001; hold1 = 1;
    set_req(0, 1, 32'h80, 32'h8888_8888, 4'hF);
    r = cyc;
    push(0, 32'h0, 1'b0, r + 3);
    push(1, 32'hCAFE_0001, 1'b0, r + 7);
    step();
    chk("post_reset_grant", 64'(grant), 64'(1));
    repeat (5) step();
    hold1 = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
